// File: rtl/delay_signed_prog_if.sv
// Sample and control bundle for delay_signed_prog. clk and rst are kept as plain
// ports on the design.
interface delay_signed_prog_if #(
  parameter int MAX_DELAY = 16,
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 1
);
  localparam int DW = $clog2(MAX_DELAY + 1);

  logic [DW-1:0]             delay;
  logic                      delay_ld;
  logic                      in_valid;
  logic [CHANNELS*WIDTH-1:0] a;
  logic                      out_valid;
  logic [CHANNELS*WIDTH-1:0] c;
  logic                      primed;

  modport master (
    output delay, delay_ld, in_valid, a,
    input  out_valid, c, primed
  );

  modport slave (
    input  delay, delay_ld, in_valid, a,
    output out_valid, c, primed
  );
endinterface

// File: rtl/delay_signed_prog.sv
// Multi-lane signed delay line. The delay is counted in accepted samples and can be
// reprogrammed at runtime; zero-fill or suppressed output is used while history builds.
module delay_signed_prog #(
  parameter int MAX_DELAY = 16,
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 1,
  parameter bit ZERO_FILL = 1'b1
) (
  input logic                clk,
  input logic                rst,
  delay_signed_prog_if.slave bus
);
  localparam int DW = $clog2(MAX_DELAY + 1);
  localparam int AW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int BW = CHANNELS * WIDTH;
  localparam logic [DW-1:0] MAXD = DW'(MAX_DELAY);
  localparam logic [AW-1:0] LAST = AW'(MAX_DELAY - 1);

  logic [BW-1:0] ring_q [MAX_DELAY];
  logic [AW-1:0] wp_q, wp_d;
  logic [DW-1:0] fill_q, fill_d;
  logic [DW-1:0] delay_q, delay_d;
  logic [BW-1:0] c_q, c_d;
  logic          out_valid_q, out_valid_d;
  logic          primed_q, primed_d;

  logic [DW-1:0] dly_clamp, dly_eff, fill_eff, wp_ext, rd_off;
  logic [AW-1:0] rd_idx;
  logic [BW-1:0] s;
  logic          prm;

  always_comb begin
    dly_clamp = (bus.delay > MAXD) ? MAXD : bus.delay;
    // A load in the same cycle as an accept applies to that sample, which then
    // sees an empty history.
    dly_eff   = bus.delay_ld ? dly_clamp : delay_q;
    fill_eff  = bus.delay_ld ? '0 : fill_q;
    wp_ext    = DW'(wp_q);
    // Modular subtract; the true result is below MAX_DELAY, so any wrap in DW bits cancels.
    rd_off    = (wp_ext >= dly_eff) ? (wp_ext - dly_eff) : (wp_ext + MAXD - dly_eff);
    rd_idx    = AW'(rd_off);
    s         = (dly_eff == '0) ? bus.a : ring_q[rd_idx];
    prm       = (fill_eff >= dly_eff);

    delay_d     = dly_eff;
    wp_d        = wp_q;
    fill_d      = fill_eff;
    c_d         = c_q;
    out_valid_d = 1'b0;
    if (bus.in_valid) begin
      wp_d        = (wp_q == LAST) ? '0 : wp_q + 1'b1;
      fill_d      = (fill_eff == MAXD) ? MAXD : fill_eff + 1'b1;
      out_valid_d = prm || ZERO_FILL;
      if (prm) begin
        c_d = s;
      end else if (ZERO_FILL) begin
        c_d = '0;
      end
    end
    primed_d = (fill_d >= delay_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      delay_q     <= dly_clamp;
      wp_q        <= '0;
      fill_q      <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      primed_q    <= 1'b0;
    end else begin
      delay_q     <= delay_d;
      wp_q        <= wp_d;
      fill_q      <= fill_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
      primed_q    <= primed_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && bus.in_valid) begin
      ring_q[wp_q] <= bus.a;
    end
  end

  assign bus.c         = c_q;
  assign bus.out_valid = out_valid_q;
  assign bus.primed    = primed_q;
endmodule

// File: tb/tb_delay_signed_prog.sv
// Self-checking bench for delay_signed_prog over three configurations: zero-fill
// single lane, suppress mode with a delay clamp, and a three-lane stream with reset.
module tb_delay_signed_prog;
  logic clk = 1'b0;
  logic rst0, rst1, rst2;
  always #5 clk = ~clk;

  delay_signed_prog_if #(.MAX_DELAY(16), .WIDTH(16), .CHANNELS(1)) b0 ();
  delay_signed_prog_if #(.MAX_DELAY(5),  .WIDTH(16), .CHANNELS(1)) b1 ();
  delay_signed_prog_if #(.MAX_DELAY(8),  .WIDTH(16), .CHANNELS(3)) b2 ();

  delay_signed_prog #(.MAX_DELAY(16), .WIDTH(16), .CHANNELS(1), .ZERO_FILL(1'b1))
    u0 (.clk(clk), .rst(rst0), .bus(b0.slave));
  delay_signed_prog #(.MAX_DELAY(5), .WIDTH(16), .CHANNELS(1), .ZERO_FILL(1'b0))
    u1 (.clk(clk), .rst(rst1), .bus(b1.slave));
  delay_signed_prog #(.MAX_DELAY(8), .WIDTH(16), .CHANNELS(3), .ZERO_FILL(1'b1))
    u2 (.clk(clk), .rst(rst2), .bus(b2.slave));

  typedef struct {
    string       nm;
    logic        ov;
    logic [47:0] c;
    logic        pr;
  } exp_t;

  typedef struct {
    string       nm;
    logic        ld;
    logic [4:0]  d;
    logic        iv;
    logic [15:0] a;
    logic        ov;
    logic [15:0] c;
    logic        pr;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        tbl[$];
  logic [47:0] last_c [3];
  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  function automatic void add(input string nm, input logic ld, input logic [4:0] d,
                              input logic iv, input logic [15:0] av, input logic ov,
                              input logic [15:0] ec, input logic pr);
    vec_t v;
    v.nm = nm; v.ld = ld; v.d = d; v.iv = iv; v.a = av; v.ov = ov; v.c = ec; v.pr = pr;
    tbl.push_back(v);
  endfunction

  // When no output is expected, c must hold the last value the bench expected.
  task automatic push(input int d, input string nm, input logic ov, input logic [47:0] ec,
                      input logic pr);
    exp_t e;
    if (ov) last_c[d] = ec;
    e.nm = nm; e.ov = ov; e.c = last_c[d]; e.pr = pr;
    sb_q.push_back(e);
  endtask

  task automatic check(input int d);
    exp_t        e;
    logic        ov, pr;
    logic [47:0] c;
    case (d)
      0:       begin ov = b0.out_valid; c = 48'(b0.c); pr = b0.primed; end
      1:       begin ov = b1.out_valid; c = 48'(b1.c); pr = b1.primed; end
      default: begin ov = b2.out_valid; c = b2.c;      pr = b2.primed; end
    endcase
    e = sb_q.pop_front();
    n_chk++;
    if (ov !== e.ov || c !== e.c) begin
      n_err++;
      $display("FAIL %s (dut%0d): out_valid=%0b c=%h, required out_valid=%0b c=%h",
               e.nm, d, ov, c, e.ov, e.c);
    end
    n_chk++;
    if (pr !== e.pr) begin
      n_err++;
      $display("FAIL %s (dut%0d): primed=%0b, required %0b", e.nm, d, pr, e.pr);
    end
  endtask

  task automatic reset_dut(input int d, input int unsigned dly, input string nm);
    @(negedge clk);
    case (d)
      0:       begin rst0 = 1'b1; b0.delay = 5'(dly); b0.in_valid = 1'b1; b0.a = '1; end
      1:       begin rst1 = 1'b1; b1.delay = 3'(dly); b1.in_valid = 1'b1; b1.a = '1; end
      default: begin rst2 = 1'b1; b2.delay = 4'(dly); b2.in_valid = 1'b1; b2.a = '1; end
    endcase
    last_c[d] = '0;
    push(d, nm, 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    b0.in_valid = 1'b0; b1.in_valid = 1'b0; b2.in_valid = 1'b0;
    check(d);
  endtask

  task automatic step0(input vec_t v);
    @(negedge clk);
    b0.delay_ld = v.ld; b0.delay = v.d; b0.in_valid = v.iv; b0.a = v.a;
    push(0, v.nm, v.ov, 48'(v.c), v.pr);
    @(posedge clk); #1;
    b0.delay_ld = 1'b0; b0.in_valid = 1'b0;
    check(0);
  endtask

  task automatic step1(input logic iv, input logic [15:0] av, input string nm,
                       input logic ov, input logic [15:0] ec, input logic pr);
    @(negedge clk);
    b1.in_valid = iv; b1.a = av;
    push(1, nm, ov, 48'(ec), pr);
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
    check(1);
  endtask

  task automatic step2(input logic [47:0] av, input string nm, input logic [47:0] ec,
                       input logic pr);
    @(negedge clk);
    b2.in_valid = 1'b1; b2.a = av;
    push(2, nm, 1'b1, ec, pr);
    @(posedge clk); #1;
    b2.in_valid = 1'b0;
    check(2);
  endtask

  function automatic logic [15:0] av1(input int k);
    return 16'(k * 2731 - 30000);
  endfunction

  function automatic logic [47:0] lanes(input int k);
    return {16'(32'h7000 + k), 16'(-3 * k), 16'(k)};
  endfunction

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    b0.delay = '0; b0.delay_ld = 1'b0; b0.in_valid = 1'b0; b0.a = '0;
    b1.delay = '0; b1.delay_ld = 1'b0; b1.in_valid = 1'b0; b1.a = '0;
    b2.delay = '0; b2.delay_ld = 1'b0; b2.in_valid = 1'b0; b2.a = '0;
    for (int i = 0; i < 3; i++) last_c[i] = '0;

    // Basic delay of 3, zero-fill, continuous ramp.
    for (int k = 1; k <= 10; k++)
      add("basic", 1'b0, 5'd3, 1'b1, 16'(k), 1'b1, (k > 3) ? 16'(k - 3) : 16'd0, k >= 3);
    // Bypass at delay 0 with extreme signed values.
    add("bypass", 1'b1, 5'd0, 1'b1, 16'h8000, 1'b1, 16'h8000, 1'b1);
    add("bypass", 1'b0, 5'd0, 1'b1, 16'h7fff, 1'b1, 16'h7fff, 1'b1);
    add("bypass", 1'b0, 5'd0, 1'b1, 16'hffff, 1'b1, 16'hffff, 1'b1);
    // Delay 2 with stalls of 0, 2, 3 and 1 cycles.
    add("stall", 1'b1, 5'd2, 1'b1, 16'd5, 1'b1, 16'd0, 1'b0);
    add("stall", 1'b0, 5'd2, 1'b1, 16'd6, 1'b1, 16'd0, 1'b1);
    for (int g = 0; g < 2; g++) add("stall_gap", 1'b0, 5'd2, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
    add("stall", 1'b0, 5'd2, 1'b1, 16'd7, 1'b1, 16'd5, 1'b1);
    for (int g = 0; g < 3; g++) add("stall_gap", 1'b0, 5'd2, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
    add("stall", 1'b0, 5'd2, 1'b1, 16'd8, 1'b1, 16'd6, 1'b1);
    add("stall_gap", 1'b0, 5'd2, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
    // Prime at delay 4, then reload to delay 1 together with an accept.
    add("reload", 1'b1, 5'd4, 1'b1, 16'd10, 1'b1, 16'd0, 1'b0);
    add("reload", 1'b0, 5'd4, 1'b1, 16'd11, 1'b1, 16'd0, 1'b0);
    add("reload", 1'b0, 5'd4, 1'b1, 16'd12, 1'b1, 16'd0, 1'b0);
    add("reload", 1'b0, 5'd4, 1'b1, 16'd13, 1'b1, 16'd0, 1'b1);
    add("reload", 1'b0, 5'd4, 1'b1, 16'd14, 1'b1, 16'd10, 1'b1);
    add("reload", 1'b1, 5'd1, 1'b1, 16'd100, 1'b1, 16'd0, 1'b1);
    add("reload", 1'b0, 5'd1, 1'b1, 16'd101, 1'b1, 16'd100, 1'b1);
    add("reload", 1'b0, 5'd1, 1'b1, 16'd102, 1'b1, 16'd101, 1'b1);
    // An out-of-range load clamps to 16, which also exercises the full ring.
    for (int k = 1; k <= 18; k++)
      add("clamp16", k == 1, 5'd31, 1'b1, 16'(1000 + k), 1'b1,
          (k > 16) ? 16'(1000 + k - 16) : 16'd0, k >= 16);

    repeat (2) @(posedge clk);
    reset_dut(0, 3, "reset0");
    foreach (tbl[i]) step0(tbl[i]);

    // Reset with delay 0: primed comes up on the first edge after release.
    reset_dut(0, 0, "reset0_d0");
    begin
      vec_t v;
      v.nm = "primed_d0"; v.ld = 1'b0; v.d = 5'd0; v.iv = 1'b0; v.a = '0;
      v.ov = 1'b0; v.c = '0; v.pr = 1'b1;
      step0(v);
    end

    // Suppress mode, requested delay 7 clamps to 5; 20 samples wrap the 5-entry ring.
    reset_dut(1, 7, "reset1");
    for (int k = 1; k <= 20; k++) begin
      if (k == 10) step1(1'b0, 16'd0, "mode0_gap", 1'b0, 16'd0, 1'b1);
      step1(1'b1, av1(k), "mode0", k > 5, (k > 5) ? av1(k - 5) : 16'd0, k >= 5);
    end

    // Three lanes at delay 2, mid-stream reset with a sample in flight, then restart.
    reset_dut(2, 2, "reset2");
    for (int k = 1; k <= 6; k++)
      step2(lanes(k), "multi", (k > 2) ? lanes(k - 2) : 48'd0, k >= 2);
    reset_dut(2, 2, "reset2_mid");
    for (int k = 1; k <= 3; k++)
      step2(lanes(10 + k), "multi_restart", (k > 2) ? lanes(10 + k - 2) : 48'd0, k >= 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/delay_signed_prog.md
# delay_signed_prog

Multi-channel, runtime-programmable signed delay line with a valid qualifier. Each accepted input sample is delayed by `delay_q` accepted samples, with delay counted in samples rather than clock cycles, so stalls on `in_valid` do not corrupt alignment. It is the successor to the fixed-depth signed delay stage. Datapaths use it to align signed streams whose latency mismatch changes with configuration.

## Interface
- `MAX_DELAY`, default 16: largest programmable delay in samples; must be at least 1.
- `WIDTH`, default 16: signed sample width per channel.
- `CHANNELS`, default 1: number of lanes. All lanes share the valid signal and the delay.
- `ZERO_FILL`, default 1: priming mode.
  - 1: emit zeros with `out_valid` set while priming.
  - 0: suppress `out_valid` while priming.
- `clk`, in, 1: clock. All logic is on the rising edge.
- `rst`, in, 1: reset. One clock; reset is synchronous and active-high.
- `delay`, in, `$clog2(MAX_DELAY+1)`: requested delay in samples.
- `delay_ld`, in, 1: single-cycle pulse that loads `delay` into `delay_q`.
- `in_valid`, in, 1: when high, `a` is accepted this cycle.
- `a`, in, `CHANNELS*WIDTH`: packed signed samples. Lane i occupies bits `[i*WIDTH +: WIDTH]`.
- `out_valid`, out, 1: `c` is valid this cycle.
- `c`, out, `CHANNELS*WIDTH`: packed signed delayed samples.
- `primed`, out, 1: history depth is at least `delay_q`, so delayed data is genuine.

## Operation
- **Storage:** ring buffer of `MAX_DELAY` entries, each `CHANNELS*WIDTH` wide.
  - Write pointer `wp` wraps from `MAX_DELAY-1` to 0. `MAX_DELAY` need not be a power of two.
  - Fill counter `fill` counts accepted samples since the last load, flush or reset. It saturates at `MAX_DELAY`.
- **Delay register `delay_q`:**
  - Loaded with min(`delay`, `MAX_DELAY`) while `rst` is high, and on any cycle with `delay_ld`=1.
  - Out-of-range values clamp to `MAX_DELAY`.
- **Load:**
  - A load also clears `fill` to 0, discarding history logically. RAM contents are not cleared.
  - `wp` is unaffected.
- **Accept** (`in_valid`=1):
  - Write `a` at `wp`, then advance `wp`.
  - Select the output sample `s`:
    - `delay_q`=0: `s = a` (bypass the RAM).
    - Otherwise: `s = ring[(wp - delay_q) mod MAX_DELAY]`, read before this cycle's write.
  - Determine priming: `prm` = (`fill` ≥ `delay_q`), using `fill` before increment.
  - Next cycle, drive the outputs from `prm`:
    - `prm`=1: `c` = `s`, `out_valid`=1.
    - `prm`=0 and `ZERO_FILL`=1: `c` = 0, `out_valid`=1.
    - `prm`=0 and `ZERO_FILL`=0: `c` holds its previous value, `out_valid`=0.
  - `fill` increments, saturating at `MAX_DELAY`.
- **No accept** (`in_valid`=0): `out_valid`=0 next cycle. `c` holds. `wp` and `fill` hold.
- **Simultaneous `delay_ld` and `in_valid`:**
  - The new delay applies to this sample.
  - This sample is evaluated with `fill`=0, so `prm` = (new `delay_q`==0).
  - Afterwards `fill` = 1.
- **Channels:** all lanes are independent in data and identical in control.
- **Arithmetic:** data is a pure copy with no sign extension and no saturation.
- **`primed`:** registered, equal to (`fill` ≥ `delay_q`) evaluated on the current state.

## Timing
- Latency from an accepted `a` to `c`/`out_valid`:
  - 1 cycle for the bypass and priming outputs.
  - `delay_q` accepted samples plus 1 cycle for the delayed data.
- Throughput: one sample per cycle; `in_valid` may be high continuously.
- Reset values:
  - `c`=0, `out_valid`=0, `primed`=0, `wp`=0, `fill`=0.
  - `delay_q` = clamped `delay`.
  - With `delay`=0 at reset, `primed` reads 1 from the first cycle after reset.
- Reset mid-stream: takes effect on the next edge. Outputs return to reset values in that cycle and any in-flight sample is dropped.
- `rst` has priority over `delay_ld` and `in_valid`.
- No combinational path from any input to any output.

## Test plan
- **Basic delay:** `WIDTH`=16, `delay`=3, `ZERO_FILL`=1, continuous `a`=1,2,3,…,10.
  - Required `c` = 0,0,0,1,2,…,7, with `out_valid` high from cycle 1 after the first accept.
  - `primed` rises after the third accept.
- **Bypass and sign:** `delay`=0, `a`=-32768, 32767, -1.
  - Required `c` equal to `a` one cycle later, bit-exact.
- **Stalled input:** `delay`=2, `a`=5,6,7,8 with `in_valid` gaps of 0–3 cycles.
  - Required `c` sequence 0,0,5,6 on `out_valid` only; no `out_valid` during gaps.
- **Mode 0 with a max-delay clamp:** `ZERO_FILL`=0, `MAX_DELAY`=5, `delay`=7.
  - `delay_q`=5.
  - The first 5 accepts produce no `out_valid`.
  - The 6th accept yields the 1st sample.
  - `wp` wraps correctly over 20 samples.
- **Reload mid-stream:** with `delay_q`=4 and primed, pulse `delay_ld` with `delay`=1 concurrently with `a`=100.
  - `c`=0 with `out_valid` (ZERO_FILL=1).
  - The next accept `a`=101 gives `c`=100.
- **Multi-channel and reset:** `CHANNELS`=3, distinct per-lane ramps.
  - Lanes stay independent.
  - Asserting `rst` mid-stream gives `c`=0, `out_valid`=0 next cycle.
  - Priming restarts after release.
